// File: rtl/ibex_lsu_pipelined.sv
// Pipelined load/store unit. Keeps up to NumOutstanding data-bus transactions
// in flight and tracks each one in an in-order FIFO, so the next request can be
// granted before older responses return. Misaligned and PMP-faulting requests
// never reach the bus; they answer from the FIFO head one cycle after
// acceptance, in order.
//
// Handshake: lsu_req_i and its attributes hold until lsu_gnt_o; a transfer
// happens in any cycle where lsu_gnt_o=1. On the bus side, data_req_o and its
// attributes are presented combinationally and the transfer happens on
// data_req_o & data_gnt_i. data_rvalid_i carries one response per granted bus
// request, in order. lsu_resp_valid_o is a one-cycle pulse with no back-pressure.
module ibex_lsu_pipelined #(
    parameter int unsigned NumOutstanding = 2,
    parameter int unsigned CntW           = $clog2(NumOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            lsu_req_i,
    output logic            lsu_gnt_o,
    input  logic            lsu_we_i,
    input  logic [1:0]      lsu_type_i,
    input  logic            lsu_sign_ext_i,
    input  logic [31:0]     lsu_addr_i,
    input  logic [31:0]     lsu_wdata_i,
    input  logic            lsu_pmp_err_i,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic            data_err_i,
    output logic [31:0]     data_addr_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [31:0]     data_wdata_o,
    input  logic [31:0]     data_rdata_i,
    output logic            lsu_resp_valid_o,
    output logic            lsu_resp_we_o,
    output logic [31:0]     lsu_rdata_o,
    output logic [31:0]     lsu_resp_addr_o,
    output logic            lsu_load_err_o,
    output logic            lsu_store_err_o,
    output logic            lsu_misaligned_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            busy_o
);

    localparam int unsigned     PtrW    = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NumOutstanding - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(NumOutstanding);

    // One tracking entry per accepted request.
    typedef struct packed {
        logic        we;
        logic [1:0]  ltype;
        logic        sign_ext;
        logic [31:0] addr;
        logic        is_local;    // answered without a bus response
        logic        misaligned;
        logic        pmp_err;
    } entry_t;

    entry_t          fifo_q [NumOutstanding];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic   misaligned, local_err, empty, full, local_acc;
    logic   push, pop, resp, bus_err, any_err;
    entry_t head, new_entry;
    logic [31:0] shifted, extracted;

    // Request classification and acceptance.
    assign misaligned = ((lsu_type_i == 2'b00) & (lsu_addr_i[1:0] != 2'b00)) |
                        ((lsu_type_i == 2'b01) & (lsu_addr_i[1:0] == 2'b11));
    assign local_err  = misaligned | lsu_pmp_err_i;
    assign empty      = (count_q == '0);
    assign full       = (count_q == FullCnt);

    // A local error is only taken with nothing in flight, so its response can
    // never collide with a bus rvalid at the head.
    assign data_req_o = lsu_req_i & ~full & ~local_err;
    assign local_acc  = lsu_req_i & local_err & empty;
    assign lsu_gnt_o  = (data_req_o & data_gnt_i) | local_acc;
    assign push       = lsu_gnt_o;

    assign data_addr_o = {lsu_addr_i[31:2], 2'b00};
    assign data_we_o   = lsu_we_i;

    // Byte enables and write-data lane rotation from the low address bits.
    always_comb begin
        data_be_o    = 4'b1111;
        data_wdata_o = lsu_wdata_i;
        unique case (lsu_type_i)
            2'b00:   data_be_o = 4'b1111;
            2'b01:   data_be_o = 4'b0011 << lsu_addr_i[1:0];
            default: data_be_o = 4'b0001 << lsu_addr_i[1:0];
        endcase
        unique case (lsu_addr_i[1:0])
            2'b00:   data_wdata_o = lsu_wdata_i;
            2'b01:   data_wdata_o = {lsu_wdata_i[23:0], lsu_wdata_i[31:24]};
            2'b10:   data_wdata_o = {lsu_wdata_i[15:0], lsu_wdata_i[31:16]};
            default: data_wdata_o = {lsu_wdata_i[7:0],  lsu_wdata_i[31:8]};
        endcase
    end

    assign new_entry = '{we:         lsu_we_i,
                         ltype:      lsu_type_i,
                         sign_ext:   lsu_sign_ext_i,
                         addr:       lsu_addr_i,
                         is_local:   local_err,
                         misaligned: misaligned,
                         pmp_err:    lsu_pmp_err_i};

    // Head response: bus entries answer on rvalid, local entries answer at once.
    assign head    = fifo_q[rptr_q];
    assign resp    = ~empty & (data_rvalid_i | head.is_local);
    assign pop     = resp;
    assign bus_err = data_rvalid_i & data_err_i & ~head.is_local;
    assign any_err = bus_err | head.pmp_err | head.misaligned;

    // Load data extraction using the head's offset, size and sign mode.
    always_comb begin
        shifted   = data_rdata_i >> {head.addr[1:0], 3'b000};
        extracted = data_rdata_i;
        unique case (head.ltype)
            2'b00:   extracted = data_rdata_i;
            2'b01:   extracted = {{16{head.sign_ext & shifted[15]}}, shifted[15:0]};
            default: extracted = {{24{head.sign_ext & shifted[7]}},  shifted[7:0]};
        endcase
    end

    assign lsu_resp_valid_o = resp;
    assign lsu_resp_we_o    = resp & head.we;
    assign lsu_resp_addr_o  = resp ? head.addr : 32'h0;
    assign lsu_rdata_o      = (resp & ~head.we & ~any_err) ? extracted : 32'h0;
    assign lsu_load_err_o   = resp & ~head.we & (bus_err | head.pmp_err);
    assign lsu_store_err_o  = resp & head.we & (bus_err | head.pmp_err);
    assign lsu_misaligned_o = resp & head.misaligned;
    assign outstanding_o    = count_q;
    assign busy_o           = ~empty;

    // Next-state pointers and occupancy; pointers wrap at NumOutstanding.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all in-flight entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Tracking storage, written at the tail on every accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumOutstanding; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wptr_q] <= new_entry;
        end
    end

endmodule

// File: tb/tb_ibex_lsu_pipelined.sv
// Directed bench for ibex_lsu_pipelined with NumOutstanding=2.
// Inputs change 1ns after a rising edge; outputs are checked 1ns later.
module tb_ibex_lsu_pipelined;

  localparam int CntW = 2;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic            lsu_req_i, lsu_gnt_o, lsu_we_i, lsu_sign_ext_i, lsu_pmp_err_i;
  logic [1:0]      lsu_type_i;
  logic [31:0]     lsu_addr_i, lsu_wdata_i;
  logic            data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
  logic [31:0]     data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]      data_be_o;
  logic            lsu_resp_valid_o, lsu_resp_we_o, lsu_load_err_o, lsu_store_err_o;
  logic            lsu_misaligned_o, busy_o;
  logic [31:0]     lsu_rdata_o, lsu_resp_addr_o;
  logic [CntW-1:0] outstanding_o;

  ibex_lsu_pipelined #(.NumOutstanding(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .lsu_req_i        (lsu_req_i),
    .lsu_gnt_o        (lsu_gnt_o),
    .lsu_we_i         (lsu_we_i),
    .lsu_type_i       (lsu_type_i),
    .lsu_sign_ext_i   (lsu_sign_ext_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_pmp_err_i    (lsu_pmp_err_i),
    .data_req_o       (data_req_o),
    .data_gnt_i       (data_gnt_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_err_i       (data_err_i),
    .data_addr_o      (data_addr_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_wdata_o     (data_wdata_o),
    .data_rdata_i     (data_rdata_i),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_we_o    (lsu_resp_we_o),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_resp_addr_o  (lsu_resp_addr_o),
    .lsu_load_err_o   (lsu_load_err_o),
    .lsu_store_err_o  (lsu_store_err_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .outstanding_o    (outstanding_o),
    .busy_o           (busy_o)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    lsu_req_i      = 1'b0;
    lsu_we_i       = 1'b0;
    lsu_type_i     = 2'b00;
    lsu_sign_ext_i = 1'b0;
    lsu_addr_i     = 32'h0;
    lsu_wdata_i    = 32'h0;
    lsu_pmp_err_i  = 1'b0;
    data_gnt_i     = 1'b0;
    data_rvalid_i  = 1'b0;
    data_err_i     = 1'b0;
    data_rdata_i   = 32'h0;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] typ, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic pmp, input logic gnt);
    lsu_req_i      = 1'b1;
    lsu_we_i       = we;
    lsu_type_i     = typ;
    lsu_sign_ext_i = sext;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wdata;
    lsu_pmp_err_i  = pmp;
    data_gnt_i     = gnt;
  endtask

  task automatic drive_rvalid(input logic [31:0] rdata, input logic err);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = err;
  endtask

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst_ni = 1'b0;
    #2;
    check("rst_outstanding", 32'(outstanding_o), 32'd0);
    check("rst_busy",        32'(busy_o),        32'd0);
    check("rst_resp_valid",  32'(lsu_resp_valid_o), 32'd0);
    check("rst_rdata",       lsu_rdata_o,        32'h0);
    check("rst_data_req",    32'(data_req_o),    32'd0);
    check("rst_gnt",         32'(lsu_gnt_o),     32'd0);
    tick(); tick();
    rst_ni = 1'b1;

    // Back-to-back loads: LW 0x100 then LH 0x106 sign-extended.
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1); #1;
    check("b2b_req0",   32'(data_req_o), 32'd1);
    check("b2b_gnt0",   32'(lsu_gnt_o),  32'd1);
    check("b2b_addr0",  data_addr_o,     32'h100);
    check("b2b_be0",    32'(data_be_o),  32'hF);
    check("b2b_cnt0",   32'(outstanding_o), 32'd0);
    tick();
    idle(); drive_req(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 1'b0, 1'b1); #1;
    check("b2b_gnt1",   32'(lsu_gnt_o),  32'd1);
    check("b2b_addr1",  data_addr_o,     32'h104);
    check("b2b_be1",    32'(data_be_o),  32'hC);
    check("b2b_cnt1",   32'(outstanding_o), 32'd1);
    tick();
    idle(); drive_rvalid(32'h11223344, 1'b0); #1;
    check("b2b_cnt2",   32'(outstanding_o), 32'd2);
    check("b2b_busy",   32'(busy_o),     32'd1);
    check("b2b_rv0",    32'(lsu_resp_valid_o), 32'd1);
    check("b2b_rd0",    lsu_rdata_o,     32'h11223344);
    check("b2b_ra0",    lsu_resp_addr_o, 32'h100);
    tick();
    idle(); drive_rvalid(32'h8000AAAA, 1'b0); #1;
    check("b2b_cnt3",   32'(outstanding_o), 32'd1);
    check("b2b_rv1",    32'(lsu_resp_valid_o), 32'd1);
    check("b2b_rd1",    lsu_rdata_o,     32'hFFFF8000);
    check("b2b_ra1",    lsu_resp_addr_o, 32'h106);
    tick();
    idle(); #1;
    check("b2b_cnt4",   32'(outstanding_o), 32'd0);
    check("b2b_idle_busy", 32'(busy_o),  32'd0);
    check("b2b_idle_rv",   32'(lsu_resp_valid_o), 32'd0);

    // Full stall: third request waits while two are in flight.
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1); #1;
    check("full_gnt0", 32'(lsu_gnt_o), 32'd1);
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1); #1;
    check("full_gnt1", 32'(lsu_gnt_o), 32'd1);
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1); #1;
    check("full_req2_stall", 32'(data_req_o), 32'd0);
    check("full_gnt2_stall", 32'(lsu_gnt_o),  32'd0);
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1);
    drive_rvalid(32'hA0A0A0A0, 1'b0); #1;
    check("full_req_on_pop", 32'(data_req_o), 32'd0);
    check("full_gnt_on_pop", 32'(lsu_gnt_o),  32'd0);
    check("full_rv_on_pop",  32'(lsu_resp_valid_o), 32'd1);
    check("full_ra_on_pop",  lsu_resp_addr_o, 32'h10);
    check("full_cnt_on_pop", 32'(outstanding_o), 32'd2);
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1); #1;
    check("full_cnt_after", 32'(outstanding_o), 32'd1);
    check("full_gnt_after", 32'(lsu_gnt_o),     32'd1);
    tick();
    idle(); drive_rvalid(32'h00000014, 1'b0); #1;
    check("full_ra1", lsu_resp_addr_o, 32'h14);
    tick();
    idle(); drive_rvalid(32'h00000018, 1'b0); #1;
    check("full_ra2", lsu_resp_addr_o, 32'h18);
    check("full_rd2", lsu_rdata_o,     32'h18);
    tick();
    idle(); #1;
    check("full_cnt_end", 32'(outstanding_o), 32'd0);

    // Store lanes: SB 0xA5 at 0x203, SH 0xBEEF at 0x201.
    tick();
    idle(); drive_req(1'b1, 2'b10, 1'b0, 32'h203, 32'h000000A5, 1'b0, 1'b1); #1;
    check("sb_be",    32'(data_be_o), 32'h8);
    check("sb_wdata", data_wdata_o,   32'hA5000000);
    check("sb_addr",  data_addr_o,    32'h200);
    check("sb_we",    32'(data_we_o), 32'd1);
    tick();
    idle(); drive_req(1'b1, 2'b01, 1'b0, 32'h201, 32'h0000BEEF, 1'b0, 1'b1); #1;
    check("sh_be",    32'(data_be_o), 32'h6);
    check("sh_wdata", data_wdata_o,   32'h00BEEF00);
    check("sh_gnt",   32'(lsu_gnt_o), 32'd1);
    tick();
    idle(); drive_rvalid(32'hDEADBEEF, 1'b0); #1;
    check("sb_resp_we",  32'(lsu_resp_we_o), 32'd1);
    check("sb_resp_rd",  lsu_rdata_o,        32'h0);
    check("sb_resp_err", 32'(lsu_store_err_o), 32'd0);
    tick();
    idle(); drive_rvalid(32'h0, 1'b0); #1;
    check("sh_resp_addr", lsu_resp_addr_o, 32'h201);
    tick();
    idle(); #1;

    // Misaligned ordering: LW 0x302 waits for LW 0x300 to complete.
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1); #1;
    check("mis_gnt_first", 32'(lsu_gnt_o), 32'd1);
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 1'b0, 1'b1); #1;
    check("mis_held_gnt", 32'(lsu_gnt_o),  32'd0);
    check("mis_held_req", 32'(data_req_o), 32'd0);
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 1'b0, 1'b1);
    drive_rvalid(32'hCAFEF00D, 1'b0); #1;
    check("mis_first_rd",  lsu_rdata_o,   32'hCAFEF00D);
    check("mis_held_gnt2", 32'(lsu_gnt_o), 32'd0);
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 1'b0, 1'b1); #1;
    check("mis_acc_gnt", 32'(lsu_gnt_o),  32'd1);
    check("mis_acc_req", 32'(data_req_o), 32'd0);
    tick();
    idle(); #1;
    check("mis_rv",    32'(lsu_resp_valid_o), 32'd1);
    check("mis_flag",  32'(lsu_misaligned_o), 32'd1);
    check("mis_addr",  lsu_resp_addr_o,       32'h302);
    check("mis_rdata", lsu_rdata_o,           32'h0);
    tick();
    idle(); #1;
    check("mis_cnt_end", 32'(outstanding_o),    32'd0);
    check("mis_rv_end",  32'(lsu_resp_valid_o), 32'd0);

    // Sub-word load extraction: LB 0x403 sign-ext, LHU 0x402 zero-ext.
    tick();
    idle(); drive_req(1'b0, 2'b10, 1'b1, 32'h403, 32'h0, 1'b0, 1'b1); #1;
    check("lb_be", 32'(data_be_o), 32'h8);
    tick();
    idle(); drive_req(1'b0, 2'b01, 1'b0, 32'h402, 32'h0, 1'b0, 1'b1); #1;
    tick();
    idle(); drive_rvalid(32'h9A123456, 1'b0); #1;
    check("lb_sext", lsu_rdata_o, 32'hFFFFFF9A);
    tick();
    idle(); drive_rvalid(32'hBEEF1234, 1'b0); #1;
    check("lhu_zext", lsu_rdata_o, 32'h0000BEEF);
    tick();
    idle(); #1;

    // Bus error on a load, then a PMP-denied store.
    tick();
    idle(); drive_req(1'b0, 2'b10, 1'b0, 32'h401, 32'h0, 1'b0, 1'b1); #1;
    check("berr_gnt", 32'(lsu_gnt_o), 32'd1);
    tick();
    idle(); drive_rvalid(32'hFFFFFFFF, 1'b1); #1;
    check("berr_load_err",  32'(lsu_load_err_o),  32'd1);
    check("berr_store_err", 32'(lsu_store_err_o), 32'd0);
    check("berr_rdata",     lsu_rdata_o,          32'h0);
    tick();
    idle(); drive_req(1'b1, 2'b00, 1'b0, 32'h500, 32'h12345678, 1'b1, 1'b1); #1;
    check("pmp_req", 32'(data_req_o), 32'd0);
    check("pmp_gnt", 32'(lsu_gnt_o),  32'd1);
    tick();
    idle(); #1;
    check("pmp_rv",        32'(lsu_resp_valid_o), 32'd1);
    check("pmp_store_err", 32'(lsu_store_err_o),  32'd1);
    check("pmp_load_err",  32'(lsu_load_err_o),   32'd0);
    check("pmp_mis",       32'(lsu_misaligned_o), 32'd0);
    check("pmp_we",        32'(lsu_resp_we_o),    32'd1);
    tick();
    idle(); #1;
    check("pmp_cnt_end", 32'(outstanding_o), 32'd0);

    // Reset with two outstanding, then a stray rvalid.
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h600, 32'h0, 1'b0, 1'b1); #1;
    tick();
    idle(); drive_req(1'b0, 2'b00, 1'b0, 32'h604, 32'h0, 1'b0, 1'b1); #1;
    tick();
    idle(); #1;
    check("rst2_cnt_before", 32'(outstanding_o), 32'd2);
    rst_ni = 1'b0; #1;
    check("rst2_cnt_async", 32'(outstanding_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    idle(); drive_rvalid(32'h55555555, 1'b0); #1;
    check("stray_rv",   32'(lsu_resp_valid_o), 32'd0);
    check("stray_rd",   lsu_rdata_o,           32'h0);
    check("stray_cnt",  32'(outstanding_o),    32'd0);
    tick();
    idle(); #1;
    check("stray_cnt_after",  32'(outstanding_o), 32'd0);
    check("stray_busy_after", 32'(busy_o),        32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
